lsu_mem_initiator: RTL and testbench

- Core-side load/store unit. It is the requesting end of the data-memory interface.
- Accepts one load/store per valid/ready handshake from the execute stage.
- Drives a word-addressed, byte-enable memory port with fixed read latency. Performs byte-lane placement for stores, and lane extraction plus sign/zero extension for loads.
- Returns a one-cycle response pulse to the writeback stage.

---
 rtl/lsu_mem_initiator.sv | 163 ++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: core-side load/store unit driving a word-addressed,
// byte-enable data memory with a fixed read latency of RD_LAT cycles.
// One request is in flight at a time: IDLE -> ISSUE -> (WAIT) -> RESP.
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip memory and respond with rsp_err=1
//   undefined : misaligned low address bits are forced to natural alignment
module lsu_mem_initiator #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_n;

    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        cnt;

    logic              legal;
    logic              misaligned;
    logic              reject;
    logic [1:0]        off;
    logic [3:0]        we_dec;
    logic [31:0]       wdata_dec;
    logic [31:0]       lane;
    logic [31:0]       ext;

    // Decode the held request: legality, alignment, lane placement and load extension
    always_comb begin
        legal      = r_we ? (r_funct3 inside {3'b000, 3'b001, 3'b010})
                          : (r_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                     ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
        reject     = !legal || misaligned;
`else
        reject     = !legal;
`endif
        // Naturally aligned lane offset; only differs from addr[1:0] when misaligned
        case (r_funct3[1:0])
            2'b01:   off = {r_addr[1], 1'b0};
            2'b10:   off = 2'b00;
            default: off = r_addr[1:0];
        endcase
        case (r_funct3[1:0])
            2'b00:   we_dec = 4'b0001 << off;
            2'b01:   we_dec = 4'b0011 << off;
            default: we_dec = 4'b1111;
        endcase
        case (r_funct3[1:0])
            2'b00:   wdata_dec = {4{r_wdata[7:0]}};
            2'b01:   wdata_dec = {2{r_wdata[15:0]}};
            default: wdata_dec = r_wdata;
        endcase
        lane = mem_rdata >> {off, 3'b000};
        case (r_funct3)
            3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext = {24'd0, lane[7:0]};
            3'b101:  ext = {16'd0, lane[15:0]};
            default: ext = lane;
        endcase
    end

    // Next-state selection
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = ISSUE;
            ISSUE:   state_n = (reject || r_we) ? RESP : WAIT;
            WAIT:    if (cnt == 3'd1) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake and memory port outputs, cleared asynchronously through the state reset
    always_comb begin
        req_ready = rst_n && (state == IDLE);
        mem_en    = (state == ISSUE) && !reject;
        mem_we    = (mem_en && r_we) ? we_dec : '0;
        mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = wdata_dec;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Request capture, read-latency counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_funct3  <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= (state_n == RESP);
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                    end
                end
                ISSUE: begin
                    if (reject) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else if (r_we) begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end else begin
                        cnt <= 3'(RD_LAT);
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        rsp_rdata <= ext;
                        rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed cases followed by random
// loads/stores, checked against a byte-array reference model of memory.
module tb_lsu_mem_initiator;

    localparam int RDL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    logic [31:0] mem [128];
    logic [31:0] pipe [RDL];
    logic [7:0]  model_mem [512];

    lsu_mem_initiator #(.ADDR_W(9), .DATA_W(32), .RD_LAT(RDL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory with RDL-cycle read pipeline; idle slots carry random junk
    assign mem_rdata = pipe[RDL-1];
    always @(posedge clk) begin
        if (mem_en && mem_we == 4'b0000) pipe[0] <= mem[mem_addr[8:2]];
        else                             pipe[0] <= $urandom;
        for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
        if (mem_en)
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction from an IDLE negedge back to an IDLE negedge
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                          input logic [31:0] wd);
        logic        legal, mis, rej;
        logic [8:0]  ea;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] exp_rd, exp_wd, got_wd;
        logic [3:0]  exp_we, got_we;
        logic [8:0]  got_addr;
        int unsigned exp_lat, lat, men, rdy_hi, spin;

        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        mis   = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        rej = !legal || mis;
`else
        rej = !legal;
`endif
        ea = (f3[1:0] == 2'd1) ? {addr[8:1], 1'b0} :
             (f3[1:0] == 2'd2) ? {addr[8:2], 2'b00} : addr;
        b = model_mem[ea];
        h = {model_mem[ea + 9'd1], model_mem[ea]};
        exp_rd = '0;
        if (!rej && !we) begin
            case (f3)
                3'd0: exp_rd = {{24{b[7]}}, b};
                3'd1: exp_rd = {{16{h[15]}}, h};
                3'd2: exp_rd = {model_mem[ea + 9'd3], model_mem[ea + 9'd2], h};
                3'd4: exp_rd = {24'd0, b};
                3'd5: exp_rd = {16'd0, h};
                default: ;
            endcase
        end
        case (f3[1:0])
            2'd0:    begin exp_we = 4'b0001 << ea[1:0]; exp_wd = {4{wd[7:0]}}; end
            2'd1:    begin exp_we = 4'b0011 << ea[1:0]; exp_wd = {2{wd[15:0]}}; end
            default: begin exp_we = 4'b1111;            exp_wd = wd; end
        endcase
        exp_lat = (rej || we) ? 2 : 2 + RDL;

        spin = 0;
        while (!req_ready && spin < 50) begin @(negedge clk); spin++; end
        check("rdy_wait", 32'(req_ready), 32'd1);

        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1;
        // keep req_valid asserted with fresh junk to show it is ignored while busy
        req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = 9'($urandom);
        req_wdata = $urandom;

        lat = 0; men = 0; rdy_hi = 0; got_we = '0; got_addr = '0; got_wd = '0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (mem_en) begin men++; got_we = mem_we; got_addr = mem_addr; got_wd = mem_wdata; end
            if (req_ready) rdy_hi++;
            if (rsp_valid) break;
        end
        req_valid = 1'b0;

        check("latency", lat, exp_lat);
        check("rsp_err", 32'(rsp_err), 32'(rej));
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("mem_en_cycles", men, rej ? 32'd0 : 32'd1);
        check("ready_busy", rdy_hi, 32'd0);
        if (!rej) begin
            check("mem_addr", 32'(got_addr), 32'({ea[8:2], 2'b00}));
            if (we) begin
                check("mem_we", 32'(got_we), 32'(exp_we));
                check("mem_wdata", got_wd, exp_wd);
                for (int k = 0; k < 4; k++)
                    if (exp_we[k]) model_mem[{ea[8:2], 2'(k)}] = exp_wd[8*k +: 8];
            end else begin
                check("mem_we_load", 32'(got_we), 32'd0);
            end
        end

        @(negedge clk);
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("ready_idle", 32'(req_ready), 32'd1);
    endtask

    // Abort a request with reset in ISSUE (store) or WAIT (load)
    task automatic reset_abort(input logic store);
        int unsigned rv;
        req_we = store; req_funct3 = 3'd2; req_addr = 9'h040; req_wdata = $urandom;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_issue_en", 32'(mem_en), 32'd1);
        if (!store) repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_en", 32'(mem_en), 32'd0);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd0);
        rv = 0;
        repeat (2) begin @(negedge clk); if (rsp_valid) rv++; end
        rst_n = 1'b1;
        #1;
        check("abort_ready_rel", 32'(req_ready), 32'd1);
        repeat (RDL + 4) begin @(negedge clk); if (rsp_valid) rv++; end
        check("abort_no_rsp", rv, 32'd0);
    endtask

    initial begin
        int unsigned nbad;
        logic [2:0]  f3;
        int unsigned r;

        for (int i = 0; i < 128; i++) mem[i] = '0;
        for (int i = 0; i < 512; i++) model_mem[i] = '0;
        for (int i = 0; i < RDL; i++) pipe[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        do_req(1'b1, 3'd0, 9'h006, 32'h0000_00A5);
        do_req(1'b1, 3'd2, 9'h000, 32'h80FF_7F01);
        do_req(1'b0, 3'd0, 9'h003, 32'h0);
        do_req(1'b0, 3'd4, 9'h003, 32'h0);
        do_req(1'b0, 3'd1, 9'h002, 32'h0);
        do_req(1'b1, 3'd2, 9'h008, 32'hDEAD_BEEF);
        do_req(1'b0, 3'd2, 9'h008, 32'h0);
        do_req(1'b0, 3'd3, 9'h010, 32'h0);
        do_req(1'b1, 3'd2, 9'h00A, 32'h1234_5678);
        do_req(1'b0, 3'd2, 9'h008, 32'h0);
        do_req(1'b0, 3'd5, 9'h009, 32'h0);

        for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 11);
            f3 = (r < 8) ? 3'(r) : 3'($urandom_range(0, 2));
            do_req(1'($urandom), f3, 9'($urandom), $urandom);
        end

        reset_abort(1'b0);
        reset_abort(1'b1);
        do_req(1'b0, 3'd2, 9'h040, 32'h0);

        nbad = 0;
        for (int i = 0; i < 128; i++)
            if (mem[i] !== {model_mem[4*i+3], model_mem[4*i+2], model_mem[4*i+1], model_mem[4*i]})
                nbad++;
        check("memory_contents", nbad, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
